// File: rtl/mvu_seq.sv
// mvu_seq: sequences one matrix-vector job over output tiles, bit-planes and input tiles,
// driving MVU control, weight/data read addresses and the per-tile result write.
`default_nettype none

module mvu_seq #(
  parameter int BWBANKA = 9,
  parameter int BDBANKA = 14,
  parameter int BPREC   = 4,
  parameter int BCNT    = 8,
  parameter int LAT     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         cfg_mode,
  input  logic [BPREC-1:0]   cfg_aprec,
  input  logic [BCNT-1:0]    cfg_ntin,
  input  logic [BCNT-1:0]    cfg_nout,
  input  logic [BWBANKA-1:0] cfg_wbase,
  input  logic [BDBANKA-1:0] cfg_dbase,
  input  logic [BDBANKA-1:0] cfg_obase,
  output logic [1:0]         mul_mode,
  output logic               acc_clr,
  output logic               acc_sh,
  output logic [BWBANKA-1:0] rdw_addr,
  output logic               rdd_en,
  input  logic               rdd_grnt,
  output logic [BDBANKA-1:0] rdd_addr,
  output logic               wrd_en,
  input  logic               wrd_grnt,
  output logic [BDBANKA-1:0] wrd_addr,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int BLAT = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, FIN} state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [BPREC-1:0]   aprec_q, aprec_d;
  logic [BCNT-1:0]    ntin_q, ntin_d;
  logic [BCNT-1:0]    nout_q, nout_d;
  logic [BDBANKA-1:0] dbase_q, dbase_d;
  logic [BDBANKA-1:0] obase_q, obase_d;
  logic [BWBANKA-1:0] row_q, row_d;
  logic [BCNT-1:0]    t_q, t_d;
  logic [BPREC-1:0]   j_q, j_d;
  logic [BCNT-1:0]    o_q, o_d;
  logic [BLAT-1:0]    lat_q, lat_d;
  logic               errf_q, errf_d;
  logic               rdd_en_q, rdd_en_d;
  logic [BWBANKA-1:0] rdw_q, rdw_d;
  logic [BDBANKA-1:0] rdd_addr_q, rdd_addr_d;
  logic               clr_q, clr_d;
  logic               sh_q, sh_d;
  logic               wrd_en_q, wrd_en_d;
  logic [BDBANKA-1:0] wrd_addr_q, wrd_addr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [BPREC-1:0]   j_inc;

  // j counts bit-planes upward (j = aprec-1-i), so the data offset within a tile is simply j.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    aprec_d    = aprec_q;
    ntin_d     = ntin_q;
    nout_d     = nout_q;
    dbase_d    = dbase_q;
    obase_d    = obase_q;
    row_d      = row_q;
    t_d        = t_q;
    j_d        = j_q;
    o_d        = o_q;
    lat_d      = lat_q;
    errf_d     = errf_q;
    rdd_en_d   = rdd_en_q;
    rdw_d      = rdw_q;
    rdd_addr_d = rdd_addr_q;
    clr_d      = clr_q;
    sh_d       = sh_q;
    wrd_en_d   = wrd_en_q;
    wrd_addr_d = wrd_addr_q;
    j_inc      = j_q + BPREC'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = cfg_mode;
          aprec_d = cfg_aprec;
          ntin_d  = cfg_ntin;
          nout_d  = cfg_nout;
          dbase_d = cfg_dbase;
          obase_d = cfg_obase;
          row_d   = cfg_wbase;
          t_d     = '0;
          j_d     = '0;
          o_d     = '0;
          if (cfg_aprec == '0 || cfg_ntin == '0 || cfg_nout == '0) begin
            errf_d  = 1'b1;
            state_d = FIN;
          end else begin
            errf_d     = 1'b0;
            state_d    = RUN;
            rdd_en_d   = 1'b1;
            rdw_d      = cfg_wbase;
            rdd_addr_d = cfg_dbase;
            clr_d      = 1'b1;
            sh_d       = 1'b0;
          end
        end
      end
      RUN: begin
        if (rdd_grnt) begin
          clr_d = 1'b0;
          sh_d  = 1'b0;
          if (t_q == ntin_q - BCNT'(1)) begin
            if (j_q == aprec_q - BPREC'(1)) begin
              rdd_en_d = 1'b0;
              lat_d    = '0;
              if (LAT == 0) begin
                state_d    = WRITE;
                wrd_en_d   = 1'b1;
                wrd_addr_d = obase_q + BDBANKA'(o_q);
              end else begin
                state_d = DRAIN;
              end
            end else begin
              t_d        = '0;
              j_d        = j_inc;
              rdw_d      = row_q;
              rdd_addr_d = dbase_q + BDBANKA'(j_inc);
              sh_d       = 1'b1;
            end
          end else begin
            t_d        = t_q + BCNT'(1);
            rdw_d      = rdw_q + BWBANKA'(1);
            rdd_addr_d = rdd_addr_q + BDBANKA'(aprec_q);
          end
        end
      end
      DRAIN: begin
        if (lat_q == BLAT'(LAT - 1)) begin
          state_d    = WRITE;
          wrd_en_d   = 1'b1;
          wrd_addr_d = obase_q + BDBANKA'(o_q);
        end else begin
          lat_d = lat_q + BLAT'(1);
        end
      end
      WRITE: begin
        if (wrd_grnt) begin
          wrd_en_d = 1'b0;
          if (o_q == nout_q - BCNT'(1)) begin
            state_d = FIN;
          end else begin
            state_d    = RUN;
            o_d        = o_q + BCNT'(1);
            row_d      = row_q + BWBANKA'(ntin_q);
            t_d        = '0;
            j_d        = '0;
            rdd_en_d   = 1'b1;
            rdw_d      = row_q + BWBANKA'(ntin_q);
            rdd_addr_d = dbase_q;
            clr_d      = 1'b1;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // done/err follow the FIN cycle by one register stage.
    done_d = (state_q == FIN);
    err_d  = (state_q == FIN) && errf_q;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      aprec_q    <= '0;
      ntin_q     <= '0;
      nout_q     <= '0;
      dbase_q    <= '0;
      obase_q    <= '0;
      row_q      <= '0;
      t_q        <= '0;
      j_q        <= '0;
      o_q        <= '0;
      lat_q      <= '0;
      errf_q     <= 1'b0;
      rdd_en_q   <= 1'b0;
      rdw_q      <= '0;
      rdd_addr_q <= '0;
      clr_q      <= 1'b0;
      sh_q       <= 1'b0;
      wrd_en_q   <= 1'b0;
      wrd_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      aprec_q    <= aprec_d;
      ntin_q     <= ntin_d;
      nout_q     <= nout_d;
      dbase_q    <= dbase_d;
      obase_q    <= obase_d;
      row_q      <= row_d;
      t_q        <= t_d;
      j_q        <= j_d;
      o_q        <= o_d;
      lat_q      <= lat_d;
      errf_q     <= errf_d;
      rdd_en_q   <= rdd_en_d;
      rdw_q      <= rdw_d;
      rdd_addr_q <= rdd_addr_d;
      clr_q      <= clr_d;
      sh_q       <= sh_d;
      wrd_en_q   <= wrd_en_d;
      wrd_addr_q <= wrd_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign mul_mode = mode_q;
  assign acc_clr  = clr_q;
  assign acc_sh   = sh_q;
  assign rdw_addr = rdw_q;
  assign rdd_en   = rdd_en_q;
  assign rdd_addr = rdd_addr_q;
  assign wrd_en   = wrd_en_q;
  assign wrd_addr = wrd_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mvu_seq.sv
// tb_mvu_seq: directed jobs with a queue-based scoreboard for mvu_seq.
`default_nettype none

module tb_mvu_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  cfg_mode = '0;
  logic [3:0]  cfg_aprec = '0;
  logic [7:0]  cfg_ntin = '0;
  logic [7:0]  cfg_nout = '0;
  logic [8:0]  cfg_wbase = '0;
  logic [13:0] cfg_dbase = '0;
  logic [13:0] cfg_obase = '0;
  logic [1:0]  mul_mode;
  logic        acc_clr, acc_sh, rdd_en, wrd_en, busy, done, err;
  logic        rdd_grnt = 1'b0;
  logic        wrd_grnt = 1'b0;
  logic [8:0]  rdw_addr;
  logic [13:0] rdd_addr, wrd_addr;

  mvu_seq dut (
    .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode), .cfg_aprec(cfg_aprec),
    .cfg_ntin(cfg_ntin), .cfg_nout(cfg_nout), .cfg_wbase(cfg_wbase), .cfg_dbase(cfg_dbase),
    .cfg_obase(cfg_obase), .mul_mode(mul_mode), .acc_clr(acc_clr), .acc_sh(acc_sh),
    .rdw_addr(rdw_addr), .rdd_en(rdd_en), .rdd_grnt(rdd_grnt), .rdd_addr(rdd_addr),
    .wrd_en(wrd_en), .wrd_grnt(wrd_grnt), .wrd_addr(wrd_addr), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int w; int d; int clr; int sh;} rd_t;
  typedef struct {int a; int c;} wr_t;
  typedef struct {int c; int e;} dn_t;
  rd_t exp_rd[$];
  wr_t exp_wr[$];
  dn_t exp_dn[$];

  int total = 0;
  int bad = 0;
  int rd_granted = 0;
  int rd_stall_step = -1;
  int rd_stall_left = 0;
  int wr_stall_left = 0;
  int done_seen = 0;

  // Hand-computed step pattern for aprec=2, ntin=2, dbase=0x100.
  int a_d[4]   = '{'h100, 'h102, 'h101, 'h103};
  int a_wo[4]  = '{0, 1, 0, 1};
  int a_clr[4] = '{1, 0, 0, 0};
  int a_sh[4]  = '{0, 0, 1, 0};

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  // Grant driver: decides grants for the coming rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rdd_en && rd_granted == rd_stall_step && rd_stall_left > 0) begin
        rdd_grnt = 1'b0;
        rd_stall_left--;
      end else begin
        rdd_grnt = 1'b1;
      end
      if (wrd_en && wr_stall_left > 0) begin
        wrd_grnt = 1'b0;
        wr_stall_left--;
      end else begin
        wrd_grnt = 1'b1;
      end
    end
  end

  // Monitor: compares every presented read/write/done against the queue heads.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (rdd_en) begin
          if (exp_rd.size() == 0) fail("rd_extra");
          else begin
            chk("rdw_addr", int'(rdw_addr), exp_rd[0].w);
            chk("rdd_addr", int'(rdd_addr), exp_rd[0].d);
            chk("acc_clr", int'(acc_clr), exp_rd[0].clr);
            chk("acc_sh", int'(acc_sh), exp_rd[0].sh);
            if (rdd_grnt) begin
              void'(exp_rd.pop_front());
              rd_granted++;
            end
          end
        end
        if (wrd_en) begin
          if (exp_wr.size() == 0) fail("wr_extra");
          else begin
            chk("wrd_addr", int'(wrd_addr), exp_wr[0].a);
            if (wrd_grnt) begin
              chk("wr_cycle", cyc, exp_wr[0].c);
              void'(exp_wr.pop_front());
            end
          end
        end
        if (done) begin
          done_seen++;
          if (exp_dn.size() == 0) fail("done_extra");
          else begin
            chk("done_cycle", cyc, exp_dn[0].c);
            chk("err", int'(err), exp_dn[0].e);
            void'(exp_dn.pop_front());
          end
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_outs"}, int'({mul_mode, acc_clr, acc_sh, rdd_en, wrd_en, busy, done, err}), 0);
    chk({tag, "_rdw"}, int'(rdw_addr), 0);
    chk({tag, "_rdd"}, int'(rdd_addr), 0);
    chk({tag, "_wrd"}, int'(wrd_addr), 0);
  endtask

  task automatic issue_job(input int mode, input int aprec, input int ntin, input int nout,
                           input int rstep, input int rlen, input int wlen, output int s);
    bit bad_cfg;
    bad_cfg = (aprec == 0) || (ntin == 0) || (nout == 0);
    @(negedge clk);
    s = cyc;
    rd_granted    = 0;
    rd_stall_step = rstep;
    rd_stall_left = rlen;
    wr_stall_left = wlen;
    if (bad_cfg) begin
      exp_dn.push_back('{s + 2, 1});
    end else begin
      for (int o = 0; o < nout; o++) begin
        for (int k = 0; k < 4; k++)
          exp_rd.push_back('{'h10 + 2 * o + a_wo[k], a_d[k], a_clr[k], a_sh[k]});
        exp_wr.push_back('{'h200 + o, s + 8 * (o + 1) + rlen + wlen});
      end
      exp_dn.push_back('{s + 8 * nout + 2 + rlen + wlen, 0});
    end
    cfg_mode  = mode[1:0];
    cfg_aprec = aprec[3:0];
    cfg_ntin  = ntin[7:0];
    cfg_nout  = nout[7:0];
    cfg_wbase = 9'h010;
    cfg_dbase = 14'h0100;
    cfg_obase = 14'h0200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_mode = 2'd0;
    #3;
    chk("busy_run", int'(busy), 1);
    chk("mul_mode", int'(mul_mode), mode);
  endtask

  task automatic finish_job(input string tag);
    int n = 0;
    while (exp_dn.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      fail({tag, "_timeout"});
      exp_dn.delete();
    end
    @(negedge clk);
    #3;
    chk({tag, "_rd_left"}, exp_rd.size(), 0);
    chk({tag, "_wr_left"}, exp_wr.size(), 0);
    chk({tag, "_busy_idle"}, int'(busy), 0);
    exp_rd.delete();
    exp_wr.delete();
  endtask

  initial begin
    int s;
    int dn0;
    #3;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    #3;
    chk_zero("reset_hold");
    rst = 1'b0;

    // A: single tile, free-running grants
    issue_job(2, 2, 2, 1, -1, 0, 0, s);
    finish_job("A");
    // B: three output tiles
    issue_job(1, 2, 2, 3, -1, 0, 0, s);
    finish_job("B");
    // C: read grant withheld 5 cycles on the second step
    issue_job(3, 2, 2, 1, 1, 5, 0, s);
    finish_job("C");
    // D: write grant withheld 4 cycles
    issue_job(2, 2, 2, 1, -1, 0, 4, s);
    finish_job("D");
    // E: ntin=0 is a config error
    issue_job(1, 2, 0, 1, -1, 0, 0, s);
    finish_job("E");

    // F: reset during DRAIN, then replay A
    issue_job(2, 2, 2, 1, -1, 0, 0, s);
    while (cyc < s + 6) @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_zero("abort");
    exp_wr.delete();
    exp_dn.delete();
    dn0 = done_seen;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_no_done", done_seen - dn0, 0);
    chk("abort_rd_left", exp_rd.size(), 0);
    issue_job(2, 2, 2, 1, -1, 0, 0, s);
    finish_job("F");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire

// File: doc/mvu_seq.md
MVU_SEQ -- requirements
Module: mvu_seq

Interface
REQ-001 Parameters SHALL be: BWBANKA, default 9, weight-bank address width; BDBANKA, default 14, data-bank address width; BPREC, default 4, activation-precision field width; BCNT, default 8, tile-count width; LAT, default 3, MVU result latency in cycles after the last granted step.
REQ-002 Ports SHALL be:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  command strobe.
- cfg_mode  in  2  multiply mode for the job.
- cfg_aprec  in  BPREC  activation bit-planes.
- cfg_ntin  in  BCNT  input tiles per output.
- cfg_nout  in  BCNT  output tiles.
- cfg_wbase  in  BWBANKA  weight base address.
- cfg_dbase  in  BDBANKA  data base address.
- cfg_obase  in  BDBANKA  output base address.
- mul_mode  out  2  multiply mode to the MVU.
- acc_clr  out  1  accumulator clear.
- acc_sh  out  1  accumulator shift-left before add.
- rdw_addr  out  BWBANKA  weight address.
- rdd_en  out  1  data read request.
- rdd_grnt  in  1  data read grant.
- rdd_addr  out  BDBANKA  data read address.
- wrd_en  out  1  result write request.
- wrd_grnt  in  1  result write grant.
- wrd_addr  out  BDBANKA  result write address.
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  config error, valid with done.

Function
REQ-003 The FSM SHALL have states IDLE, RUN, DRAIN, WRITE and FIN.
REQ-004 In IDLE, start=1 SHALL latch all cfg_* inputs and go to RUN; start is ignored in every other state.
REQ-005 If cfg_aprec=0, cfg_ntin=0 or cfg_nout=0 at start, the block SHALL go to FIN instead of RUN, issue no rdd_en or wrd_en, and assert err=1 with done.
REQ-006 In RUN, steps SHALL be issued for the current output tile o; bit i runs from aprec-1 down to 0 (outer loop) and input tile t runs from 0 to ntin-1 (inner loop).
REQ-007 Each step SHALL drive rdd_en=1, rdw_addr=wbase+o*ntin+t and rdd_addr=dbase+t*aprec+(aprec-1-i), both truncated modulo their widths (wrap, no error).
REQ-008 acc_clr SHALL be 1 only on the first step of a tile; acc_sh SHALL be 1 only on steps with t=0 that are not the first step of the tile.
REQ-009 A step SHALL complete only on a cycle with rdd_grnt=1.
REQ-010 While rdd_grnt=0, rdd_en, both addresses, acc_clr and acc_sh SHALL hold unchanged and the counters SHALL NOT advance.
REQ-011 After the last granted step of a tile, the FSM SHALL enter DRAIN with rdd_en=0, acc_clr=0 and acc_sh=0, and stay there exactly LAT cycles.
REQ-012 WRITE SHALL drive wrd_en=1 with wrd_addr=obase+o (modulo 2^BDBANKA), holding both until wrd_grnt=1.
REQ-013 On the granted write cycle, if o<nout-1 the FSM SHALL increment o and return to RUN on the next cycle; otherwise it SHALL go to FIN.
REQ-014 FIN SHALL last one cycle with done=1 and then return to IDLE; a start in that same cycle is ignored.
REQ-015 busy SHALL be 1 in RUN, DRAIN, WRITE and FIN, and 0 in IDLE.
REQ-016 mul_mode SHALL equal the latched cfg_mode from the cycle after start until the next accepted start.
REQ-017 Without stalls, one tile SHALL take aprec*ntin+LAT+1 cycles, and the first rdd_en SHALL appear the cycle after start.
REQ-018 All outputs SHALL be registered.

Reset
REQ-019 While rst=1, the FSM SHALL be in IDLE and every output SHALL be 0, including mul_mode, all addresses, done and err.
REQ-020 Assertion of rst mid-job SHALL abort the job immediately, with no done pulse.
REQ-021 After rst deasserts, the first start accepted SHALL be one sampled on a rising clk edge with rst=0.

Verification
REQ-022 Case A: start with aprec=2, ntin=2, nout=1, wbase=0x10, dbase=0x100, obase=0x200, all grants=1.
- rdd_addr SHALL be 0x100, 0x102, 0x101, 0x103.
- rdw_addr SHALL be 0x10, 0x11, 0x10, 0x11.
- acc_clr SHALL be 1,0,0,0 and acc_sh SHALL be 0,0,1,0.
- After 3 idle cycles, wrd_en=1 at 0x200, then done.
REQ-023 Case B: the Case A config with nout=3 SHALL produce writes to 0x200, 0x201 and 0x202, each preceded by acc_clr; done SHALL come 3*(4+3+1)+1 cycles after the first rdd_en.
REQ-024 Case C: rdd_grnt=0 for 5 cycles on step 2 SHALL hold rdd_addr=0x102 and acc_sh=0 for those 5 cycles; the address sequence SHALL be otherwise unchanged.
REQ-025 Case D: wrd_grnt withheld for 4 cycles SHALL hold wrd_en=1 and wrd_addr=0x200 for 4 cycles, with no new rdd_en and done delayed by 4 cycles.
REQ-026 Case E: start with cfg_ntin=0 SHALL give done=1 and err=1 two cycles later, with no rdd_en or wrd_en ever asserted.
REQ-027 Case F: rst asserted during DRAIN SHALL immediately zero all outputs and give no done; a fresh start SHALL then replay Case A exactly.
